// File: rtl/font_loader_pkg.sv
// font_loader_pkg
//   Shared definitions for the font RAM loader: header command encodings,
//   loader state encoding and glyph geometry constants.
//   No ports (package).
package font_loader_pkg;

   localparam int ROWS_PER_GLYPH = 8;   // font rows per character cell
   localparam int GLYPH_COUNT    = 64;  // characters addressable by a 6-bit code
   localparam int ROW_BITS       = 3;   // width of the font row index

   // Header byte bits [7:6]
   typedef enum logic [1:0] {
      CMD_LOAD    = 2'b00,
      CMD_FILL    = 2'b01,
      CMD_CLEAR   = 2'b10,
      CMD_INVALID = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LOAD_ROW   = 3'd1,
      ST_FILL_BYTE  = 3'd2,
      ST_FILL_WRITE = 3'd3,
      ST_CLEAR      = 3'd4
   } state_e;

endpackage

// File: rtl/font_ram_loader.sv
// font_ram_loader
//   Turns a byte stream of glyph commands into single-cycle write strobes for
//   the font RAM write port. Header byte = {command[1:0], char code[5:0]}.
//   LOAD takes 8 row bytes, FILL takes one pattern byte written to all rows,
//   CLEAR zeroes the whole RAM, the fourth encoding is dropped with cmd_error.
// Ports
//   clock, reset        : system clock, asynchronous active-high reset
//   in_data/in_valid    : stream byte and its valid
//   in_ready            : byte accepted when in_valid & in_ready
//   wr_en/wr_address/wr_data : registered font RAM write port,
//                         address = {char code, font row}, data bit 7 = column 0
//   busy                : loader is not idle
//   glyph_done          : pulse with the last write of a command
//   cmd_error           : pulse the cycle after an invalid header is accepted
module font_ram_loader
   import font_loader_pkg::*;
#(
   parameter int address_width = 9,
   parameter int data_width    = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [data_width-1:0]    in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     wr_en,
   output logic [address_width-1:0] wr_address,
   output logic [data_width-1:0]    wr_data,
   output logic                     busy,
   output logic                     glyph_done,
   output logic                     cmd_error
);

   localparam int CODE_BITS = address_width - ROW_BITS;
   localparam logic [ROW_BITS-1:0]      ROW_LAST = ROW_BITS'(ROWS_PER_GLYPH - 1);
   localparam logic [address_width-1:0] CLR_LAST =
      address_width'(GLYPH_COUNT * ROWS_PER_GLYPH - 1);

   state_e                   state_q, state_d;
   logic [ROW_BITS-1:0]      row_q, row_d;
   logic [address_width-1:0] clr_q, clr_d;
   logic [CODE_BITS-1:0]     code_q, code_d;
   logic [data_width-1:0]    pat_q, pat_d;
   logic                     wr_en_q, wr_en_d;
   logic [address_width-1:0] wr_address_q, wr_address_d;
   logic [data_width-1:0]    wr_data_q, wr_data_d;
   logic                     glyph_done_q, glyph_done_d;
   logic                     cmd_error_q, cmd_error_d;
   logic                     transfer;

   // Ready depends only on state (and reset), never on in_valid.
   assign in_ready = ((state_q == ST_IDLE) || (state_q == ST_LOAD_ROW) ||
                      (state_q == ST_FILL_BYTE)) && !reset;
   assign transfer = in_valid && in_ready;
   assign busy     = (state_q != ST_IDLE);

   assign wr_en      = wr_en_q;
   assign wr_address = wr_address_q;
   assign wr_data    = wr_data_q;
   assign glyph_done = glyph_done_q;
   assign cmd_error  = cmd_error_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         row_q        <= '0;
         clr_q        <= '0;
         code_q       <= '0;
         pat_q        <= '0;
         wr_en_q      <= 1'b0;
         wr_address_q <= '0;
         wr_data_q    <= '0;
         glyph_done_q <= 1'b0;
         cmd_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         clr_q        <= clr_d;
         code_q       <= code_d;
         pat_q        <= pat_d;
         wr_en_q      <= wr_en_d;
         wr_address_q <= wr_address_d;
         wr_data_q    <= wr_data_d;
         glyph_done_q <= glyph_done_d;
         cmd_error_q  <= cmd_error_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      clr_d        = clr_q;
      code_d       = code_q;
      pat_d        = pat_q;
      wr_en_d      = 1'b0;
      wr_address_d = wr_address_q;
      wr_data_d    = wr_data_q;
      glyph_done_d = 1'b0;
      cmd_error_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (transfer) begin
               code_d = in_data[CODE_BITS-1:0];
               case (cmd_e'(in_data[7:6]))
                  CMD_LOAD: begin
                     row_d   = '0;
                     state_d = ST_LOAD_ROW;
                  end
                  CMD_FILL: begin
                     state_d = ST_FILL_BYTE;
                  end
                  CMD_CLEAR: begin
                     // Address 0 is written straight from the header so the
                     // 512 writes follow the header with no bubble.
                     wr_en_d      = 1'b1;
                     wr_address_d = '0;
                     wr_data_d    = '0;
                     clr_d        = address_width'(1);
                     state_d      = ST_CLEAR;
                  end
                  default: begin
                     cmd_error_d = 1'b1;
                  end
               endcase
            end
         end

         ST_LOAD_ROW: begin
            if (transfer) begin
               wr_en_d      = 1'b1;
               wr_address_d = {code_q, row_q};
               wr_data_d    = in_data;
               row_d        = row_q + 1'b1;
               if (row_q == ROW_LAST) begin
                  glyph_done_d = 1'b1;
                  state_d      = ST_IDLE;
               end
            end
         end

         ST_FILL_BYTE: begin
            if (transfer) begin
               // Row 0 goes out with the pattern byte; FILL_WRITE does rows 1..7.
               pat_d        = in_data;
               wr_en_d      = 1'b1;
               wr_address_d = {code_q, {ROW_BITS{1'b0}}};
               wr_data_d    = in_data;
               row_d        = ROW_BITS'(1);
               state_d      = ST_FILL_WRITE;
            end
         end

         ST_FILL_WRITE: begin
            // Row counter back at 0 means all eight rows have been issued.
            if (row_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               wr_en_d      = 1'b1;
               wr_address_d = {code_q, row_q};
               wr_data_d    = pat_q;
               row_d        = row_q + 1'b1;
               glyph_done_d = (row_q == ROW_LAST);
            end
         end

         ST_CLEAR: begin
            if (clr_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               wr_en_d      = 1'b1;
               wr_address_d = clr_q;
               wr_data_d    = '0;
               clr_d        = clr_q + 1'b1;
               glyph_done_d = (clr_q == CLR_LAST);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: doc/font_ram_loader.md
# font_ram_loader

Write-side counterpart of the character ROM path: accepts a byte stream of glyph commands over a valid/ready handshake and turns it into single-cycle write strobes for the dual-port font RAM whose read port feeds the VGA character pixel mux. Font RAM address is {character code, font row}, data is one 8-pixel row with bit 7 = font column 0 (leftmost pixel), matching the read side's inverted column select. Sits between the host/UART byte source and the font RAM write port; it lets glyphs be replaced at run time instead of being fixed at synthesis.

## Interface
- address_width, 9, font RAM address width; upper address_width-3 bits are the character code (must be 9: header packs a 6-bit code)
- data_width, 8, font RAM row width (must be 8: one stream byte per row)
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle; transfer = in_valid & in_ready
- wr_en  out  1  font RAM write strobe, one write per cycle
- wr_address  out  9  {character code[5:0], font row[2:0]}
- wr_data  out  8  row bits, bit 7 = column 0
- busy  out  1  high whenever state is not IDLE
- glyph_done  out  1  one-cycle pulse coincident with the last write of a command
- cmd_error  out  1  one-cycle pulse the cycle after an invalid header is accepted

## Operation
- Header byte: [7:6] command, [5:0] character code. 00 LOAD (8 row bytes follow, row 0 first), 01 FILL (1 pattern byte follows, written to all 8 rows), 10 CLEAR (no payload; writes 0x00 to all 512 addresses, code ignored), 11 invalid (byte dropped, cmd_error pulsed, stay IDLE).
- States: IDLE -> LOAD_ROW (cmd 00) / FILL_BYTE (cmd 01) / CLEAR (cmd 10). LOAD_ROW counts 8 accepted bytes then -> IDLE. FILL_BYTE accepts pattern -> FILL_WRITE, which issues 8 writes then -> IDLE. CLEAR issues 512 writes then -> IDLE.
- in_ready = 1 in IDLE, LOAD_ROW, FILL_BYTE; 0 in FILL_WRITE, CLEAR, and while reset is asserted.
- Row counter 3 bits, clear counter 9 bits; both wrap to 0 on completion, never mid-command.
- Gaps in in_valid stall LOAD_ROW/FILL_BYTE indefinitely; no timeout. No writes occur on stalled cycles.
- wr_en, wr_address, wr_data, glyph_done, cmd_error are registered outputs.
- Reset values: wr_en 0, wr_address 0, wr_data 0, busy 0, glyph_done 0, cmd_error 0, state IDLE, counters 0. Reset mid-command abandons it; rows already written stay written, no glyph_done.

## Timing
- LOAD: byte accepted at cycle N -> wr_en at N+1 with that byte. Header at 0, rows at 1..8 (no stalls) -> writes 2..9, glyph_done at 9; next header may be accepted at cycle 9.
- FILL: header 0, pattern 1, writes 2..9 (rows 0..7), glyph_done 9, in_ready low cycles 2..9, high again cycle 10.
- CLEAR: header 0, writes 1..512 at addresses 0..511, glyph_done at 512, in_ready low 1..512.
- cmd_error: invalid header at N -> pulse at N+1; in_ready stays high, next header accepted at N+1.
- Header accepted in IDLE on the cycle a previous LOAD completes is legal; back-to-back commands lose no cycles.

## Structure
- Package font_loader_pkg: command encodings (CMD_LOAD, CMD_FILL, CMD_CLEAR, CMD_INVALID), state enum, ROWS_PER_GLYPH = 8, GLYPH_COUNT = 64.
- Single module, no sub-modules; the font RAM (dual-port block) is instantiated at the VGA controller level, not here.

## Test plan
- LOAD char 0x05 (header 0x05) rows 0x18,0x24,0x42,0x7E,0x42,0x42,0x42,0x00 at full rate -> writes to addresses 0x028..0x02F with those bytes on cycles 2..9, glyph_done at 9.
- FILL char 0x3F (header 0x7F) pattern 0xAA -> 8 writes of 0xAA to 0x1F8..0x1FF, in_ready low for those 8 cycles.
- CLEAR (header 0x80) -> 512 writes of 0x00, addresses 0..511 in order, busy high throughout, single glyph_done.
- Header 0xC3 -> cmd_error pulse next cycle, no wr_en, following LOAD header processed normally.
- LOAD with in_valid toggled every other cycle -> exactly 8 writes, correct addresses, glyph_done only after 8th row.
- Assert reset after 3 LOAD rows -> all outputs 0 immediately, state IDLE, no glyph_done; fresh LOAD after release completes correctly.
